// File: rtl/snake_move_controller.sv
// Command-side controller for snake_game: button conditioning, direction filter, tick generator and session FSM.
// Define SNAKE_CTRL_PAUSE_EN to compile the PAUSE state (start toggles RUN/PAUSE); otherwise start is ignored in RUN.
module snake_move_controller #(
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          TICK_PERIOD     = 5000000,
    parameter int          TICK_STEP       = 250000,
    parameter int          TICK_MIN        = 1000000,
    parameter int          SCORE_BITS      = 10,
    parameter logic [1:0]  INIT_MOVE       = 2'b01
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_up,
    input  logic                  btn_right,
    input  logic                  btn_down,
    input  logic                  btn_left,
    input  logic                  btn_start,
    input  logic                  game_over,
    input  logic [SCORE_BITS-1:0] score,
    output logic [1:0]            move,
    output logic                  game_tick,
    output logic                  game_rst,
    output logic                  running,
    output logic                  paused
);

    localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PMAX = (TICK_PERIOD > TICK_MIN) ? TICK_PERIOD : TICK_MIN;
    localparam int CW   = $clog2(PMAX + 1);

`ifdef SNAKE_CTRL_PAUSE_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_OVER = 2'd2, S_PAUSE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_OVER = 2'd2} state_t;
`endif

    state_t state, state_next;

    // Button bit order: 0 up, 1 right, 2 down, 3 left, 4 start
    logic [4:0]    btn_raw;
    logic [4:0]    btn_sync_p0, btn_sync_p1;
    logic [4:0]    stable, stable_d, press;
    logic [DW-1:0] db_cnt [5];

    logic [CW-1:0] tick_cnt, period_q;
    logic [1:0]    pending;
    logic [63:0]   sub_full;
    logic          start_pulse, dir_hit, run_start, tick_now, cnt_advance;
    logic [1:0]    dir_sel;

    // Saturating period: never wraps below zero, never drops under the floor.
    function automatic logic [CW-1:0] tick_period(input logic [63:0] sub);
        logic [63:0] p;
        if (sub >= 64'(TICK_PERIOD)) begin
            p = 64'(TICK_MIN);
        end else begin
            p = 64'(TICK_PERIOD) - sub;
            if (p < 64'(TICK_MIN))
                p = 64'(TICK_MIN);
        end
        return CW'(p);
    endfunction

    assign btn_raw     = {btn_start, btn_left, btn_down, btn_right, btn_up};
    assign sub_full    = 64'(score) * 64'(TICK_STEP);
    assign start_pulse = press[4];

    // Stage p0/p1: synchroniser; then debounce and registered rising-edge pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_sync_p0 <= '0;
            btn_sync_p1 <= '0;
            stable      <= '0;
            stable_d    <= '0;
            press       <= '0;
            for (int i = 0; i < 5; i++)
                db_cnt[i] <= '0;
        end else begin
            btn_sync_p0 <= btn_raw;
            btn_sync_p1 <= btn_sync_p0;
            stable_d    <= stable;
            press       <= stable & ~stable_d;
            for (int i = 0; i < 5; i++) begin
                if (btn_sync_p1[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    stable[i] <= ~stable[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        dir_hit = 1'b1;
        dir_sel = 2'b00;
        if (press[0])      dir_sel = 2'b00;
        else if (press[1]) dir_sel = 2'b01;
        else if (press[2]) dir_sel = 2'b10;
        else if (press[3]) dir_sel = 2'b11;
        else               dir_hit = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        run_start   = 1'b0;
        tick_now    = 1'b0;
        cnt_advance = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_pulse) begin
                    state_next = S_RUN;
                    run_start  = 1'b1;
                end
            end
            S_RUN: begin
                if (game_over)
                    state_next = S_OVER;
`ifdef SNAKE_CTRL_PAUSE_EN
                else if (start_pulse)
                    state_next = S_PAUSE;
`endif
                else begin
                    cnt_advance = 1'b1;
                    tick_now    = (tick_cnt == period_q - 1'b1);
                end
            end
`ifdef SNAKE_CTRL_PAUSE_EN
            S_PAUSE: begin
                if (start_pulse)
                    state_next = S_RUN;
            end
`endif
            S_OVER: begin
                if (start_pulse)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Tick counter, direction commit and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt  <= '0;
            period_q  <= '0;
            move      <= INIT_MOVE;
            pending   <= INIT_MOVE;
            game_tick <= 1'b0;
            game_rst  <= 1'b0;
            running   <= 1'b0;
        end else begin
            game_tick <= tick_now;
            game_rst  <= run_start;
            running   <= (state_next == S_RUN);
            if (run_start || tick_now) begin
                tick_cnt <= '0;
                period_q <= tick_period(sub_full);
            end else if (cnt_advance) begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            if (state == S_IDLE || state_next == S_IDLE) begin
                move    <= INIT_MOVE;
                pending <= INIT_MOVE;
            end else if (state == S_RUN) begin
                if (tick_now)
                    move <= pending;
                // Reversal check is against the committed move, so a quick
                // up-then-down within one interval is still accepted.
                if (dir_hit && dir_sel != (move ^ 2'b10))
                    pending <= dir_sel;
            end
        end
    end

`ifdef SNAKE_CTRL_PAUSE_EN
    always_ff @(posedge clk) begin
        if (reset) paused <= 1'b0;
        else       paused <= (state_next == S_PAUSE);
    end
`else
    assign paused = 1'b0;
`endif

endmodule

// File: tb/tb_snake_move_controller.sv
// Randomized bench for snake_move_controller against a window-based debounce and countdown session model.
module tb_snake_move_controller;

    localparam int         DEB  = 4;
    localparam int         TP   = 20;
    localparam int         TS   = 3;
    localparam int         TM   = 8;
    localparam int         SB   = 10;
    localparam logic [1:0] INIT = 2'b01;
`ifdef SNAKE_CTRL_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic          clk, reset;
    logic          btn_up, btn_right, btn_down, btn_left, btn_start;
    logic          game_over;
    logic [SB-1:0] score;
    logic [1:0]    move;
    logic          game_tick, game_rst, running, paused;

    snake_move_controller #(
        .DEBOUNCE_CYCLES(DEB), .TICK_PERIOD(TP), .TICK_STEP(TS),
        .TICK_MIN(TM), .SCORE_BITS(SB), .INIT_MOVE(INIT)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_right(btn_right), .btn_down(btn_down),
        .btn_left(btn_left), .btn_start(btn_start),
        .game_over(game_over), .score(score),
        .move(move), .game_tick(game_tick), .game_rst(game_rst),
        .running(running), .paused(paused)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 run, 2 pause, 3 over; m_rem counts
    // advancing RUN cycles left until the next tick.
    int        m_mode, m_move, m_pend, m_rem, m_tick, m_rst;
    bit [15:0] hist [5];
    bit [4:0]  m_stable, m_press, m_rose;

    function automatic int period_of(input int s);
        int p;
        p = TP - s * TS;
        if (p < TM) p = TM;
        return p;
    endfunction

    // Stable flips once the synchronised level has differed for DEB cycles.
    function automatic bit window_differs(input bit [15:0] h, input bit s);
        for (int k = 1; k <= DEB; k++)
            if (h[k] == s) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_move = INIT; m_pend = INIT; m_rem = 0;
        m_tick = 0; m_rst = 0;
        m_stable = '0; m_press = '0; m_rose = '0;
        for (int i = 0; i < 5; i++) hist[i] = '0;
    endtask

    task automatic model_step();
        bit [4:0] raw;
        int       old_move, old_pend, w;
        raw = {btn_start, btn_left, btn_down, btn_right, btn_up};
        if (reset) begin
            model_reset();
            return;
        end
        m_tick = 0;
        m_rst  = 0;
        case (m_mode)
            0: begin
                m_move = INIT; m_pend = INIT;
                if (m_press[4]) begin
                    m_mode = 1; m_rst = 1; m_rem = period_of(int'(score));
                end
            end
            1: begin
                old_move = m_move;
                old_pend = m_pend;
                w = -1;
                for (int d = 3; d >= 0; d--)
                    if (m_press[d]) w = d;
                if (w >= 0 && w != (old_move ^ 2)) m_pend = w;
                if (game_over) m_mode = 3;
                else if (PAUSE_EN && m_press[4]) m_mode = 2;
                else begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_tick = 1;
                        m_move = old_pend;
                        m_rem  = period_of(int'(score));
                    end
                end
            end
            2: if (m_press[4]) m_mode = 1;
            default: if (m_press[4]) begin
                m_mode = 0; m_move = INIT; m_pend = INIT;
            end
        endcase
        m_press = m_rose;
        m_rose  = '0;
        for (int i = 0; i < 5; i++) begin
            if (window_differs(hist[i], m_stable[i])) begin
                m_stable[i] = ~m_stable[i];
                m_rose[i]   = m_stable[i];
            end
            hist[i] = {hist[i][14:0], raw[i]};
        end
    endtask

    int edge_no = 0;

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_eq("game_tick", int'(game_tick), m_tick);
        check_eq("game_rst",  int'(game_rst),  m_rst);
        check_eq("running",   int'(running),   int'(m_mode == 1));
        check_eq("paused",    int'(paused),    int'(PAUSE_EN && m_mode == 2));
        check_eq("move",      int'(move),      m_move);
        edge_no++;
        @(negedge clk);
    endtask

    int hold [5];
    int go_hold;
    int rst_edge, tick_edge;
    int score_pick [6] = '{0, 1, 3, 5, 1023, 2};

    initial begin
        reset = 1'b1;
        {btn_up, btn_right, btn_down, btn_left, btn_start} = '0;
        game_over = 1'b0;
        score     = '0;
        model_reset();
        @(negedge clk);
        repeat (3) cycle();
        reset = 1'b0;
        repeat (4) cycle();

        // Start held for 10 cycles: game_rst one edge after the press pulse,
        // first tick a full period later.
        rst_edge  = -1;
        tick_edge = -1;
        for (int j = 0; j < 30; j++) begin
            btn_start = (j < 10);
            cycle();
            if (game_rst  && rst_edge  < 0) rst_edge  = j + 1;
            if (game_tick && tick_edge < 0) tick_edge = j + 1;
        end
        check_eq("rst_latency", rst_edge, DEB + 4);
        check_eq("first_tick_gap", tick_edge - rst_edge, TP);

        for (int i = 0; i < 5; i++) hold[i] = 0;
        go_hold = 0;
        for (int n = 0; n < 6000; n++) begin
            for (int i = 0; i < 4; i++)
                if (hold[i] == 0 && $urandom_range(0, 29) == 0)
                    hold[i] = $urandom_range(1, 9);
            if ($urandom_range(0, 99) == 0) begin
                hold[0] = 6; hold[3] = 6;
            end
            if (hold[4] == 0 && $urandom_range(0, 119) == 0)
                hold[4] = $urandom_range(1, 10);
            if (m_mode == 1 && go_hold == 0 && $urandom_range(0, 149) == 0)
                go_hold = $urandom_range(1, 4);
            if ($urandom_range(0, 59) == 0)
                score = SB'(score_pick[$urandom_range(0, 5)]);
            btn_up    = (hold[0] > 0);
            btn_right = (hold[1] > 0);
            btn_down  = (hold[2] > 0);
            btn_left  = (hold[3] > 0);
            btn_start = (hold[4] > 0);
            game_over = (go_hold > 0);
            for (int i = 0; i < 5; i++) if (hold[i] > 0) hold[i]--;
            if (go_hold > 0) go_hold--;
            reset = (n == 3000 || n == 3001);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
